adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001: Parameter WIDTH, default 32, operand and sum width; only 32 is supported because the adder instance is fixed-width.
REQ-002: Parameter CNT_W, default 16, width of the per-requester grant counters.
REQ-003: Clk  input  1  single clock, all state updates on rising edge.
REQ-004: Reset  input  1  synchronous, active-high reset.
REQ-005: ReqA  input  1  requester A has an add pending; must hold with operands stable until granted.
REQ-006: InA1, InA2  input  32 each  requester A operands.
REQ-007: CinA  input  1  requester A carry-in.
REQ-008: GntA  output  1  requester A transfer accepted this cycle; transfer occurs when ReqA && GntA at a rising edge.
REQ-009: ReqB, InB1, InB2, CinB, GntB  same widths and meanings as REQ-005 to REQ-008, for requester B.
REQ-010: Sum  output  32  registered result.
REQ-011: Cout  output  1  registered carry-out.
REQ-012: Ovf  output  1  registered signed two's-complement overflow.
REQ-013: ValidOut  output  1  result registers hold a valid result.
REQ-014: Owner  output  1  result owner, 0 = A, 1 = B.
REQ-015: Ack  input  1  consumer takes the result; sampled only while ValidOut is high.
REQ-016: CountA, CountB  output  CNT_W each  saturating count of grants issued to A and to B.

Function
REQ-017: The sum is computed by one instance of the team's 32-bit ripple adder (FA_dataflow_32bit), shared by both requesters; no second adder.
REQ-018: The FSM has two states: IDLE and RESULT.
REQ-019: In IDLE, GntA and GntB are combinational; at most one is high.
 - Only ReqA high: GntA=1.
 - Only ReqB high: GntB=1.
 - Both high: grant goes to the requester selected by the priority pointer Prio (0 = A, 1 = B).
REQ-020: In RESULT, GntA=GntB=0 regardless of requests.
REQ-021: On an IDLE-cycle transfer, the selected operands and carry-in drive the adder.
 - At the edge: Sum, Cout, Ovf, Owner load, ValidOut goes to 1, state goes to RESULT.
 - Latency from accepting edge to ValidOut visible: 1 cycle.
REQ-022: Arithmetic rules.
 - {Cout,Sum} = In1 + In2 + Cin, modulo 2^33.
 - Ovf = (In1[31] == In2[31]) && (Sum[31] != In1[31]).
REQ-023: In RESULT, Sum/Cout/Ovf/Owner/ValidOut hold stable until Ack=1 at an edge.
REQ-024: On Ack=1 in RESULT, at that edge:
 - ValidOut clears to 0.
 - State returns to IDLE.
 - Prio is set to the requester not equal to Owner.
REQ-025: Ack while in IDLE is ignored.
REQ-026: Maximum throughput is one result per 2 cycles (accept cycle, then Ack cycle).
REQ-027: Prio updates only per REQ-024, so a lone requester is served repeatedly and strict alternation holds under continuous contention.
REQ-028: CountX increments by 1 at each transfer edge for requester X, saturates at 2^CNT_W-1, and never wraps.
REQ-029: Sum, Cout and Ovf are outputs of the registers loaded per REQ-021, never the live adder output.

Reset
REQ-030: When Reset=1 at an edge, the block enters IDLE and clears all of the following to 0:
 - Prio (A has priority).
 - ValidOut, Owner, Sum, Cout, Ovf.
 - CountA, CountB.
REQ-031: Reset takes precedence over all other inputs in the same cycle.
 - A pending result is discarded without Ack.
 - A simultaneous request is not counted.
REQ-032: While Reset=1, GntA=GntB=0.

Verification
REQ-033: Single request: ReqA=1, InA1=0x0000_0005, InA2=0x0000_0003, CinA=1 -> GntA=1 in that cycle; next cycle ValidOut=1, Sum=0x0000_0009, Cout=0, Ovf=0, Owner=0, CountA=1.
REQ-034: Carry and overflow cases.
 - 0xFFFF_FFFF + 0x0000_0001, Cin=0 -> Sum=0, Cout=1, Ovf=0.
 - 0x7FFF_FFFF + 0x0000_0001 -> Sum=0x8000_0000, Cout=0, Ovf=1.
REQ-035: Contention after reset: ReqA=ReqB=1 held, Ack held 1 -> grants alternate A, B, A, B at 2-cycle spacing; Owner sequence is 0,1,0,1.
REQ-036: Held result: ValidOut=1 with Ack=0 for 5 cycles while ReqB=1 and B operands change -> Sum/Owner unchanged, GntB=0 throughout; Ack=1 -> ValidOut=0 next cycle, GntB=1 in the following IDLE cycle.
REQ-037: Reset mid-result: Reset=1 while ValidOut=1 -> next cycle ValidOut=0, Sum=0, CountA=CountB=0, Prio=A; a simultaneous ReqB is neither granted nor counted.
REQ-038: Saturation: with CNT_W overridden to 2, grant A five times -> CountA reads 1,2,3,3,3.

Source files
------------

// File: rtl/adder_arbiter.sv
// Two-requester add unit: one shared 32-bit ripple adder behind a
// round-robin grant, with a registered result and Ack handshake.

module FA_dataflow_32bit (
  input  logic [31:0] In1,
  input  logic [31:0] In2,
  input  logic        Cin,
  output logic [31:0] Sum,
  output logic        Cout
);

  logic [32:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign Sum[i]  = In1[i] ^ In2[i] ^ c[i];
    assign c[i+1]  = (In1[i] & In2[i]) |
                     (c[i] & (In1[i] ^ In2[i]));
  end

  assign Cout = c[32];

endmodule

module adder_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ReqA,
  input  logic [WIDTH-1:0] InA1,
  input  logic [WIDTH-1:0] InA2,
  input  logic             CinA,
  output logic             GntA,
  input  logic             ReqB,
  input  logic [WIDTH-1:0] InB1,
  input  logic [WIDTH-1:0] InB2,
  input  logic             CinB,
  output logic             GntB,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             ValidOut,
  output logic             Owner,
  input  logic             Ack,
  output logic [CNT_W-1:0] CountA,
  output logic [CNT_W-1:0] CountB
);

  typedef enum logic {
    IDLE,
    RESULT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic             valid_q, valid_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

  logic [WIDTH-1:0] op1, op2, add_sum;
  logic             op_cin, add_cout;

  // Operand mux steered by the grant; A is the default path.
  assign op1    = GntB ? InB1 : InA1;
  assign op2    = GntB ? InB2 : InA2;
  assign op_cin = GntB ? CinB : CinA;

  FA_dataflow_32bit u_add (
    .In1  (op1),
    .In2  (op2),
    .Cin  (op_cin),
    .Sum  (add_sum),
    .Cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    valid_d = valid_q;
    owner_d = owner_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    GntA    = 1'b0;
    GntB    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!Reset) begin
          GntA = ReqA && (!ReqB || !prio_q);
          GntB = ReqB && (!ReqA || prio_q);
        end
        if (GntA || GntB) begin
          state_d = RESULT;
          valid_d = 1'b1;
          owner_d = GntB;
          sum_d   = add_sum;
          cout_d  = add_cout;
          ovf_d   = (op1[WIDTH-1] == op2[WIDTH-1]) &&
                    (add_sum[WIDTH-1] != op1[WIDTH-1]);
          if (GntA && cnt_a_q != CNT_MAX)
            cnt_a_d = cnt_a_q + 1'b1;
          if (GntB && cnt_b_q != CNT_MAX)
            cnt_b_d = cnt_b_q + 1'b1;
        end
      end
      RESULT: begin
        if (Ack) begin
          state_d = IDLE;
          valid_d = 1'b0;
          prio_d  = ~owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      valid_q <= 1'b0;
      owner_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      valid_q <= valid_d;
      owner_q <= owner_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign Sum      = sum_q;
  assign Cout     = cout_q;
  assign Ovf      = ovf_q;
  assign ValidOut = valid_q;
  assign Owner    = owner_q;
  assign CountA   = cnt_a_q;
  assign CountB   = cnt_b_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: grants, results, hold, reset
// and counter saturation on a second narrow-counter instance.

module tb_adder_arbiter;

  logic        Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset, ReqA, CinA, ReqB, CinB, Ack;
  logic [31:0] InA1, InA2, InB1, InB2;
  logic        GntA, GntB, Cout, Ovf, ValidOut, Owner;
  logic [31:0] Sum;
  logic [15:0] CountA, CountB;

  logic        Reset2, ReqA2, Ack2, GntA2, GntB2;
  logic        Cout2, Ovf2, Valid2, Owner2;
  logic [31:0] Sum2;
  logic [1:0]  CountA2, CountB2;
  logic        zero1;
  logic [31:0] one32, zero32;

  adder_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .ReqA(ReqA), .InA1(InA1), .InA2(InA2), .CinA(CinA), .GntA(GntA),
    .ReqB(ReqB), .InB1(InB1), .InB2(InB2), .CinB(CinB), .GntB(GntB),
    .Sum(Sum), .Cout(Cout), .Ovf(Ovf), .ValidOut(ValidOut),
    .Owner(Owner), .Ack(Ack), .CountA(CountA), .CountB(CountB)
  );

  adder_arbiter #(.CNT_W(2)) dut2 (
    .Clk(Clk), .Reset(Reset2),
    .ReqA(ReqA2), .InA1(one32), .InA2(one32), .CinA(zero1), .GntA(GntA2),
    .ReqB(zero1), .InB1(zero32), .InB2(zero32), .CinB(zero1), .GntB(GntB2),
    .Sum(Sum2), .Cout(Cout2), .Ovf(Ovf2), .ValidOut(Valid2),
    .Owner(Owner2), .Ack(Ack2), .CountA(CountA2), .CountB(CountB2)
  );

  typedef struct packed {
    logic        owner;
    logic        cout;
    logic        ovf;
    logic [31:0] sum;
  } res_t;

  res_t sb[$];
  res_t got, exp_r;
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_ca = 0;
  int   exp_cb = 0;

  assign got = {Owner, Cout, Ovf, Sum};

  function automatic res_t model(logic own, logic [31:0] a,
                                 logic [31:0] b, logic c);
    logic [32:0] t;
    res_t r;
    t = {1'b0, a} + {1'b0, b} + {32'b0, c};
    r.owner = own;
    r.sum   = t[31:0];
    r.cout  = t[32];
    r.ovf   = (a[31] == b[31]) && (t[31] != a[31]);
    return r;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    ReqA  = 1'b1;
    InA1  = 32'h5;
    InA2  = 32'h3;
    step();
    n_chk++;
    if ({GntA, GntB} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_gnt got=%b exp=00", {GntA, GntB});
    end
    step();
    Reset = 1'b0;
    ReqA  = 1'b0;
    n_chk++;
    if ({ValidOut, got, CountA, CountB} !== '0) begin
      n_fail++;
      $display("FAIL reset_state v=%b res=%h ca=%0d cb=%0d exp all 0",
               ValidOut, got, CountA, CountB);
    end
    exp_ca = 0;
    exp_cb = 0;
  endtask

  task automatic test_single();
    Ack = 1'b1;
    step();
    Ack = 1'b0;
    n_chk++;
    if (ValidOut !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ack got=%b exp=0", ValidOut);
    end
    ReqA = 1'b1;
    InA1 = 32'h0000_0005;
    InA2 = 32'h0000_0003;
    CinA = 1'b1;
    #1;
    n_chk++;
    if ({GntA, GntB} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_gnt got=%b exp=10", {GntA, GntB});
    end
    sb.push_back(model(1'b0, InA1, InA2, CinA));
    exp_ca++;
    step();
    ReqA = 1'b0;
    exp_r = sb.pop_front();
    n_chk++;
    if (ValidOut !== 1'b1 || got !== exp_r || exp_r.sum !== 32'h9) begin
      n_fail++;
      $display("FAIL single_res v=%b got=%h exp=%h", ValidOut, got, exp_r);
    end
    n_chk++;
    if (CountA !== 16'(exp_ca)) begin
      n_fail++;
      $display("FAIL single_cnt got=%0d exp=%0d", CountA, exp_ca);
    end
    Ack = 1'b1;
    step();
    Ack = 1'b0;
    n_chk++;
    if (ValidOut !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ack got=%b exp=0", ValidOut);
    end
  endtask

  task automatic test_carry();
    logic [31:0] a_tab [2];
    a_tab[0] = 32'hFFFF_FFFF;
    a_tab[1] = 32'h7FFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      ReqB = (i == 0);
      ReqA = (i == 1);
      InB1 = a_tab[i];
      InA1 = a_tab[i];
      InB2 = 32'h1;
      InA2 = 32'h1;
      CinB = 1'b0;
      CinA = 1'b0;
      #1;
      n_chk++;
      if ({GntA, GntB} !== {ReqA, ReqB}) begin
        n_fail++;
        $display("FAIL carry_gnt%0d got=%b exp=%b", i,
                 {GntA, GntB}, {ReqA, ReqB});
      end
      sb.push_back(model(ReqB, a_tab[i], 32'h1, 1'b0));
      if (ReqA) exp_ca++;
      else exp_cb++;
      step();
      ReqA = 1'b0;
      ReqB = 1'b0;
      exp_r = sb.pop_front();
      n_chk++;
      if (ValidOut !== 1'b1 || got !== exp_r) begin
        n_fail++;
        $display("FAIL carry_res%0d v=%b got=%h exp=%h", i,
                 ValidOut, got, exp_r);
      end
      Ack = 1'b1;
      step();
      Ack = 1'b0;
    end
    n_chk++;
    if (CountA !== 16'(exp_ca) || CountB !== 16'(exp_cb)) begin
      n_fail++;
      $display("FAIL carry_cnt got=%0d/%0d exp=%0d/%0d",
               CountA, CountB, exp_ca, exp_cb);
    end
  endtask

  task automatic test_contention();
    logic own;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    exp_ca = 0;
    exp_cb = 0;
    ReqA = 1'b1;
    ReqB = 1'b1;
    Ack  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        InA1 = $urandom;
        InA2 = $urandom;
        InB1 = $urandom;
        InB2 = $urandom;
        CinA = 1'($urandom_range(0, 1));
        CinB = 1'($urandom_range(0, 1));
        #1;
        own = ((k / 2) % 2) == 1;
        n_chk++;
        if ({GntA, GntB} !== {!own, own}) begin
          n_fail++;
          $display("FAIL cont_gnt%0d got=%b exp=%b", k,
                   {GntA, GntB}, {!own, own});
        end
        if (own) begin
          sb.push_back(model(1'b1, InB1, InB2, CinB));
          exp_cb++;
        end else begin
          sb.push_back(model(1'b0, InA1, InA2, CinA));
          exp_ca++;
        end
      end else begin
        n_chk++;
        if (sb.size() == 0 || ValidOut !== 1'b1 || got !== sb[0] ||
            {GntA, GntB} !== 2'b00) begin
          n_fail++;
          $display("FAIL cont_res%0d v=%b g=%b got=%h", k,
                   ValidOut, {GntA, GntB}, got);
        end
        if (sb.size() != 0) void'(sb.pop_front());
      end
      step();
    end
    ReqA = 1'b0;
    ReqB = 1'b0;
    Ack  = 1'b0;
    n_chk++;
    if (CountA !== 16'(exp_ca) || CountB !== 16'(exp_cb)) begin
      n_fail++;
      $display("FAIL cont_cnt got=%0d/%0d exp=%0d/%0d",
               CountA, CountB, exp_ca, exp_cb);
    end
  endtask

  task automatic test_hold();
    ReqA = 1'b1;
    InA1 = 32'h1234_5678;
    InA2 = 32'h8765_4321;
    CinA = 1'b1;
    #1;
    n_chk++;
    if ({GntA, GntB} !== 2'b10) begin
      n_fail++;
      $display("FAIL hold_gnt got=%b exp=10", {GntA, GntB});
    end
    sb.push_back(model(1'b0, InA1, InA2, CinA));
    exp_ca++;
    step();
    ReqA = 1'b0;
    ReqB = 1'b1;
    for (int i = 0; i < 5; i++) begin
      InB1 = $urandom;
      InB2 = $urandom;
      CinB = 1'($urandom_range(0, 1));
      #1;
      n_chk++;
      if (ValidOut !== 1'b1 || got !== sb[0] || GntB !== 1'b0) begin
        n_fail++;
        $display("FAIL hold%0d v=%b gb=%b got=%h exp=%h", i,
                 ValidOut, GntB, got, sb[0]);
      end
      step();
    end
    void'(sb.pop_front());
    Ack = 1'b1;
    step();
    Ack = 1'b0;
    n_chk++;
    if (ValidOut !== 1'b0 || GntB !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release v=%b gb=%b exp v=0 gb=1", ValidOut, GntB);
    end
    sb.push_back(model(1'b1, InB1, InB2, CinB));
    exp_cb++;
    step();
    ReqB = 1'b0;
    exp_r = sb.pop_front();
    n_chk++;
    if (ValidOut !== 1'b1 || got !== exp_r) begin
      n_fail++;
      $display("FAIL hold_b_res v=%b got=%h exp=%h", ValidOut, got, exp_r);
    end
    Ack = 1'b1;
    step();
    Ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    ReqA = 1'b1;
    InA1 = 32'hDEAD_BEEF;
    InA2 = 32'h0BAD_F00D;
    CinA = 1'b0;
    #1;
    sb.push_back(model(1'b0, InA1, InA2, CinA));
    step();
    ReqA = 1'b0;
    exp_r = sb.pop_front();
    n_chk++;
    if (ValidOut !== 1'b1 || got !== exp_r) begin
      n_fail++;
      $display("FAIL mid_res v=%b got=%h exp=%h", ValidOut, got, exp_r);
    end
    Reset = 1'b1;
    ReqB  = 1'b1;
    InB1  = 32'h1;
    InB2  = 32'h2;
    CinB  = 1'b0;
    #1;
    n_chk++;
    if ({GntA, GntB} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_gnt got=%b exp=00", {GntA, GntB});
    end
    step();
    Reset = 1'b0;
    exp_ca = 0;
    exp_cb = 0;
    n_chk++;
    if ({ValidOut, Sum, CountA, CountB} !== '0) begin
      n_fail++;
      $display("FAIL mid_clear v=%b sum=%h ca=%0d cb=%0d exp all 0",
               ValidOut, Sum, CountA, CountB);
    end
    ReqA = 1'b1;
    #1;
    n_chk++;
    if ({GntA, GntB} !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_prio got=%b exp=10", {GntA, GntB});
    end
    sb.push_back(model(1'b0, InA1, InA2, CinA));
    exp_ca++;
    step();
    ReqA = 1'b0;
    ReqB = 1'b0;
    exp_r = sb.pop_front();
    n_chk++;
    if (got !== exp_r || CountA !== 16'(exp_ca) ||
        CountB !== 16'(exp_cb)) begin
      n_fail++;
      $display("FAIL mid_after got=%h exp=%h ca=%0d cb=%0d", got, exp_r,
               CountA, CountB);
    end
    Ack = 1'b1;
    step();
    Ack = 1'b0;
  endtask

  task automatic test_saturation();
    logic [1:0] exp_c;
    Reset2 = 1'b1;
    step();
    Reset2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ReqA2 = 1'b1;
      #1;
      n_chk++;
      if (GntA2 !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_gnt%0d got=%b exp=1", i, GntA2);
      end
      step();
      ReqA2 = 1'b0;
      exp_c = (i < 3) ? 2'(i + 1) : 2'd3;
      n_chk++;
      if (CountA2 !== exp_c) begin
        n_fail++;
        $display("FAIL sat_cnt%0d got=%0d exp=%0d", i, CountA2, exp_c);
      end
      Ack2 = 1'b1;
      step();
      Ack2 = 1'b0;
    end
  endtask

  initial begin
    Reset = 1'b1;  ReqA = 1'b0;  ReqB = 1'b0;  Ack = 1'b0;
    CinA = 1'b0;   CinB = 1'b0;
    InA1 = '0;     InA2 = '0;    InB1 = '0;    InB2 = '0;
    Reset2 = 1'b1; ReqA2 = 1'b0; Ack2 = 1'b0;
    zero1 = 1'b0;  one32 = 32'h1; zero32 = '0;
    step();
    test_reset();
    test_single();
    test_carry();
    test_contention();
    test_hold();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
